// File: rtl/fixed_block_quantizer_if.sv
// Stream bundle for fixed_block_quantizer: input beat channel plus quantized output channel.
// master is the surrounding environment, slave is the quantizer.
interface fixed_block_quantizer_if #(
    parameter int IN_WIDTH      = 16,
    parameter int OUT_WIDTH     = 8,
    parameter int PARALLELISM   = 4,
    parameter int MAX_NUM_WIDTH = OUT_WIDTH
);
    logic signed [IN_WIDTH-1:0]  data_in [PARALLELISM];
    logic                        data_in_valid;
    logic                        data_in_ready;
    logic signed [OUT_WIDTH-1:0] data_out [PARALLELISM];
    logic [MAX_NUM_WIDTH-1:0]    data_out_max_num;
    logic                        data_out_valid;
    logic                        data_out_ready;

    modport master (
        output data_in, data_in_valid, data_out_ready,
        input  data_in_ready, data_out, data_out_max_num, data_out_valid
    );

    modport slave (
        input  data_in, data_in_valid, data_out_ready,
        output data_in_ready, data_out, data_out_max_num, data_out_valid
    );
endinterface

// File: rtl/fixed_block_quantizer.sv
// Per-block power-of-two activation quantizer: buffers one block, finds its absmax, replays it
// as saturated OUT_WIDTH integers. Define FIXED_BLOCK_QUANTIZER_PINGPONG_EN for two banks.
module fixed_block_quantizer #(
    parameter int IN_WIDTH      = 16,
    parameter int IN_FRAC_WIDTH = 8,
    parameter int OUT_WIDTH     = 8,
    parameter int PARALLELISM   = 4,
    parameter int TENSOR_SIZE   = 16,
    parameter int IN_DEPTH      = TENSOR_SIZE / PARALLELISM,
    parameter int MAX_NUM_WIDTH = OUT_WIDTH
) (
    input logic                   clk,
    input logic                   rst,
    fixed_block_quantizer_if.slave bus
);

    localparam int CntW     = (IN_DEPTH > 1) ? $clog2(IN_DEPTH) : 1;
    localparam int ExtW     = IN_WIDTH + 1;
    localparam int Headroom = OUT_WIDTH - 2;
    localparam logic signed [ExtW-1:0] QMax = ExtW'((1 << (OUT_WIDTH - 1)) - 1);
    localparam logic signed [ExtW-1:0] QMin = -QMax;

    typedef logic [CntW-1:0] cnt_t;

    if (TENSOR_SIZE % PARALLELISM != 0 || IN_DEPTH * PARALLELISM != TENSOR_SIZE) begin : g_bad_depth
        $error("TENSOR_SIZE must equal IN_DEPTH * PARALLELISM");
    end
    if (IN_FRAC_WIDTH < 0 || IN_FRAC_WIDTH > IN_WIDTH) begin : g_bad_frac
        $error("IN_FRAC_WIDTH out of range");
    end
    if ((1 << MAX_NUM_WIDTH) <= IN_WIDTH) begin : g_bad_max_num
        $error("MAX_NUM_WIDTH cannot hold 0..IN_WIDTH");
    end

    // Unsigned magnitude, so the most negative input maps to 2^(IN_WIDTH-1) without overflow.
    function automatic logic [IN_WIDTH-1:0] abs_of(input logic signed [IN_WIDTH-1:0] x);
        return x[IN_WIDTH-1] ? (~x + 1'b1) : x;
    endfunction

    function automatic logic [MAX_NUM_WIDTH-1:0] scale_of(input logic [IN_WIDTH-1:0] amax);
        int m;
        m = 0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (amax[i]) m = i;
        end
        return (m > Headroom) ? MAX_NUM_WIDTH'(m - Headroom) : '0;
    endfunction

    // Round half up, then clamp symmetrically so -2^(OUT_WIDTH-1) never appears.
    function automatic logic signed [OUT_WIDTH-1:0] quant(input logic signed [IN_WIDTH-1:0] x,
                                                          input logic [MAX_NUM_WIDTH-1:0] s);
        logic signed [ExtW-1:0] bias;
        logic signed [ExtW-1:0] sh;
        bias = (s == '0) ? '0 : (ExtW'(1) <<< (s - 1'b1));
        sh   = ($signed({x[IN_WIDTH-1], x}) + bias) >>> s;
        if (sh > QMax) sh = QMax;
        else if (sh < QMin) sh = QMin;
        return sh[OUT_WIDTH-1:0];
    endfunction

    logic                        in_ready;
    logic                        in_fire;
    logic                        out_fire;
    logic                        wr_last;
    logic                        rd_last;
    cnt_t                        wr_cnt_q;
    cnt_t                        rd_cnt_q;
    cnt_t                        rd_nxt;
    logic [IN_WIDTH-1:0]         absmax_q;
    logic [IN_WIDTH-1:0]         absmax_acc;
    logic                        out_valid_q;
    logic signed [OUT_WIDTH-1:0] out_q [PARALLELISM];
    logic signed [OUT_WIDTH-1:0] q_first [PARALLELISM];
    logic signed [OUT_WIDTH-1:0] q_next [PARALLELISM];
    logic [MAX_NUM_WIDTH-1:0]    max_num;

    assign in_fire  = bus.data_in_valid & in_ready;
    assign out_fire = out_valid_q & bus.data_out_ready;
    assign wr_last  = (wr_cnt_q == cnt_t'(IN_DEPTH - 1));
    assign rd_last  = (rd_cnt_q == cnt_t'(IN_DEPTH - 1));
    assign rd_nxt   = rd_last ? '0 : rd_cnt_q + 1'b1;

    assign bus.data_in_ready    = in_ready;
    assign bus.data_out_valid   = out_valid_q;
    assign bus.data_out         = out_q;
    assign bus.data_out_max_num = max_num;

    always_comb begin
        absmax_acc = absmax_q;
        for (int l = 0; l < PARALLELISM; l++) begin
            if (abs_of(bus.data_in[l]) > absmax_acc) absmax_acc = abs_of(bus.data_in[l]);
        end
    end

`ifdef FIXED_BLOCK_QUANTIZER_PINGPONG_EN

    logic                        wr_bank_q;
    logic                        rd_bank_q;
    logic [1:0]                  full_q;
    logic [1:0]                  full_d;
    logic [MAX_NUM_WIDTH-1:0]    s_bank_q [2];
    logic [MAX_NUM_WIDTH-1:0]    max_num_q;
    logic signed [IN_WIDTH-1:0]  buf_q [2][IN_DEPTH][PARALLELISM];

    // The scale is taken from the completed absmax on the last beat, so no SCAN cycle is spent.
    assign in_ready = ~full_q[wr_bank_q];
    assign max_num  = max_num_q;

    always_comb begin
        full_d = full_q;
        if (in_fire && wr_last) full_d[wr_bank_q] = 1'b1;
        if (out_fire && rd_last) full_d[rd_bank_q] = 1'b0;
        for (int l = 0; l < PARALLELISM; l++) begin
            q_first[l] = quant(buf_q[rd_bank_q][0][l], s_bank_q[rd_bank_q]);
            q_next[l]  = quant(buf_q[rd_bank_q][rd_nxt][l], s_bank_q[rd_bank_q]);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            absmax_q    <= '0;
            wr_bank_q   <= 1'b0;
            rd_bank_q   <= 1'b0;
            full_q      <= '0;
            max_num_q   <= '0;
            out_valid_q <= 1'b0;
            for (int b = 0; b < 2; b++) s_bank_q[b] <= '0;
            for (int l = 0; l < PARALLELISM; l++) out_q[l] <= '0;
        end else begin
            full_q <= full_d;
            if (in_fire) begin
                wr_cnt_q <= wr_last ? '0 : wr_cnt_q + 1'b1;
                if (wr_last) begin
                    s_bank_q[wr_bank_q] <= scale_of(absmax_acc);
                    absmax_q            <= '0;
                    wr_bank_q           <= ~wr_bank_q;
                end else begin
                    absmax_q <= absmax_acc;
                end
            end
            if (out_fire) begin
                if (rd_last) begin
                    out_valid_q <= 1'b0;
                    rd_cnt_q    <= '0;
                    rd_bank_q   <= ~rd_bank_q;
                end else begin
                    rd_cnt_q <= rd_nxt;
                    for (int l = 0; l < PARALLELISM; l++) out_q[l] <= q_next[l];
                end
            end else if (!out_valid_q && full_q[rd_bank_q]) begin
                out_valid_q <= 1'b1;
                max_num_q   <= s_bank_q[rd_bank_q];
                for (int l = 0; l < PARALLELISM; l++) out_q[l] <= q_first[l];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int l = 0; l < PARALLELISM; l++) buf_q[wr_bank_q][wr_cnt_q][l] <= bus.data_in[l];
        end
    end

`else

    typedef enum logic [1:0] {StCollect, StScan, StEmit} state_e;

    state_e                      state_q;
    state_e                      state_d;
    logic [MAX_NUM_WIDTH-1:0]    s_q;
    logic [MAX_NUM_WIDTH-1:0]    s_scan;
    logic signed [IN_WIDTH-1:0]  buf_q [IN_DEPTH][PARALLELISM];

    assign max_num = s_q;
    assign s_scan  = scale_of(absmax_q);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= StCollect;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        unique case (state_q)
            StCollect: begin
                in_ready = 1'b1;
                if (bus.data_in_valid && wr_last) state_d = StScan;
            end
            StScan:  state_d = StEmit;
            StEmit:  if (out_fire && rd_last) state_d = StCollect;
            default: state_d = StCollect;
        endcase
    end

    // Beat 0 is quantized with the freshly derived scale so it is registered by the end of SCAN.
    always_comb begin
        for (int l = 0; l < PARALLELISM; l++) begin
            q_first[l] = quant(buf_q[0][l], s_scan);
            q_next[l]  = quant(buf_q[rd_nxt][l], s_q);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_cnt_q    <= '0;
            rd_cnt_q    <= '0;
            absmax_q    <= '0;
            s_q         <= '0;
            out_valid_q <= 1'b0;
            for (int l = 0; l < PARALLELISM; l++) out_q[l] <= '0;
        end else begin
            if (in_fire) begin
                wr_cnt_q <= wr_last ? '0 : wr_cnt_q + 1'b1;
                absmax_q <= absmax_acc;
            end
            if (state_q == StScan) begin
                s_q         <= s_scan;
                absmax_q    <= '0;
                rd_cnt_q    <= '0;
                out_valid_q <= 1'b1;
                for (int l = 0; l < PARALLELISM; l++) out_q[l] <= q_first[l];
            end else if (state_q == StEmit && out_fire) begin
                if (rd_last) begin
                    out_valid_q <= 1'b0;
                    rd_cnt_q    <= '0;
                end else begin
                    rd_cnt_q <= rd_nxt;
                    for (int l = 0; l < PARALLELISM; l++) out_q[l] <= q_next[l];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (in_fire) begin
            for (int l = 0; l < PARALLELISM; l++) buf_q[wr_cnt_q][l] <= bus.data_in[l];
        end
    end

`endif

endmodule
